x8_mul_err_monitor: RTL
=======================

Name: x8_mul_err_monitor

Overview:
- Downstream consumer of the 8x8 approximate multiplier.
- Accepts a stream of (a, b, approximate product) samples over a valid/ready handshake and computes the exact product internally.
- Accumulates error statistics over a fixed window of samples, then presents one report over a second valid/ready handshake.
- Used for on-chip or simulation characterisation of the N8/N4 approximation settings.

Parameters:
- WINDOW, 256: samples per report window; legal range is WINDOW >= 1.
- SUM_W, 24: width of the saturating error-sum accumulator; legal range is SUM_W >= 16.
- CW, derived as $clog2(WINDOW+1): width of the sample and nonzero-error counters; not user-set.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the window.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- in_prod  in  16  approximate product under test.
- rpt_valid  out  1  report valid.
- rpt_ready  in  1  report consumer ready.
- rpt_sum_err  out  SUM_W  sum of |error| over the window, saturating.
- rpt_max_err  out  16  maximum |error| in the window.
- rpt_nz_cnt  out  CW  number of samples with error != 0.
- rpt_sat  out  1  rpt_sum_err saturated during the window.
- rpt_bias  out  SUM_W  signed sum of (prod - exact); present only with X8_ERR_BIAS_EN.

Behaviour:
- Reset (async, rst=1): state=ACCUM, all accumulators and counters = 0, pipeline valid = 0.
  - in_ready=0 while rst is high; in_ready=1 from the first clock edge after release.
  - rpt_valid=0; all rpt_* outputs = 0.
- Accept rule: a sample is accepted on a rising edge with in_valid && in_ready.
- Stage 1 (registered, 1-cycle latency):
  - exact = in_a*in_b, unsigned 16-bit, maximum 65025.
  - err = |in_prod - exact|, 16-bit; fits because both operands are at most 65535.
- Stage 2: on the cycle after acceptance, the staged err is folded into the stats.
  - sum_err += err; on overflow, clamp to 2^SUM_W-1 and set the sticky sat flag.
  - max_err = max(max_err, err).
  - nz_cnt += (err != 0).
- FSM states:
  - ACCUM: in_ready=1. A sample counter increments on each accept. The accept that makes the count equal WINDOW moves the FSM to DRAIN.
  - DRAIN: one cycle, in_ready=0. The last staged error is folded in; then go to REPORT.
  - REPORT: rpt_valid=1 and in_ready=0. rpt_* are stable registered copies of the stats and do not change while rpt_valid && !rpt_ready. On rpt_valid && rpt_ready: stats and counter clear, go to ACCUM, rpt_valid=0 next cycle.
- Back-to-back accepts in ACCUM are allowed every cycle; with no stalls, window throughput is WINDOW + 2 cycles plus the report wait.
- Window boundary: the sample counter never exceeds WINDOW. WINDOW=1 goes ACCUM→DRAIN after a single accept.
- clear (synchronous, any state):
  - Next state is ACCUM; stats, counter, pipeline valid and rpt_valid are all zeroed.
  - A sample presented in the same cycle as clear is discarded even if in_valid && in_ready.
  - A report pending in the same cycle as clear is dropped, even if rpt_ready=1.
- Reset mid-window: all partial stats are lost and no report is emitted.
- Idle: in ACCUM with in_valid=0, no state changes.

Optional Feature:
- X8_ERR_BIAS_EN defined:
  - A signed SUM_W-bit accumulator adds (in_prod - exact), sign-extended, per sample.
  - It saturates at the signed limits; saturation of the bias also sets rpt_sat.
  - Output on rpt_bias, cleared with the other stats.
- X8_ERR_BIAS_EN undefined: no bias logic, and the rpt_bias port is absent.

Test Plan:
- Reset, then WINDOW=4 with samples (3,5,15),(3,5,14),(10,10,96),(2,2,6), no stalls:
  - Report: rpt_sum_err=7, rpt_max_err=4, rpt_nz_cnt=3, rpt_sat=0.
  - With X8_ERR_BIAS_EN: rpt_bias=-3.
  - rpt_valid rises exactly 2 cycles after the 4th accept.
- Exact stream of 4 samples where in_prod=a*b (including 255,255,65025): all stats 0, rpt_nz_cnt=0.
- Backpressure: hold rpt_ready=0 for 10 cycles after rpt_valid.
  - rpt_valid stays 1, outputs unchanged, in_ready=0 throughout.
  - rpt_ready=1 → next cycle rpt_valid=0, in_ready=1, stats 0.
- Saturation: SUM_W=16, WINDOW=4, every sample (0,0,30000).
  - rpt_sum_err=65535, rpt_max_err=30000, rpt_sat=1, rpt_nz_cnt=4.
- clear asserted with in_valid=1 after 2 accepts:
  - That sample is dropped, the counter restarts.
  - The next 4 samples produce a report reflecting only those 4.
- rst pulsed asynchronously between clock edges mid-window:
  - Outputs go to reset values immediately, with no report.
  - in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/x8_mul_err_monitor.sv
// -----------------------------------------------------------------------------
// x8_mul_err_monitor
//
// Error-statistics monitor for the 8x8 approximate multiplier. Each accepted
// sample (a, b, approximate product) is compared against the exact product;
// the absolute error is folded into window statistics. After WINDOW samples a
// single report is offered on a valid/ready handshake.
//
// Pipeline: stage 1 registers |prod - exact| for the accepted sample, stage 2
// folds the staged error into the running stats on the following cycle.
// FSM: ACCUM (accepting) -> DRAIN (fold last sample) -> REPORT (hold report).
//
// Optional feature macro: X8_ERR_BIAS_EN adds a signed saturating bias
// accumulator of (prod - exact) and the rpt_bias_o port.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   clear_i       synchronous flush of window, report and pipeline
//   in_valid_i    sample valid
//   in_ready_o    sample can be accepted (registered)
//   in_a_i        multiplicand
//   in_b_i        multiplier
//   in_prod_i     approximate product under test
//   rpt_valid_o   report valid
//   rpt_ready_i   report consumer ready
//   rpt_sum_err_o saturating sum of |error| over the window
//   rpt_max_err_o maximum |error| in the window
//   rpt_nz_cnt_o  number of samples with nonzero error
//   rpt_sat_o     a window accumulator saturated
//   rpt_bias_o    signed sum of (prod - exact)   [X8_ERR_BIAS_EN only]
// -----------------------------------------------------------------------------
module x8_mul_err_monitor #(
  parameter int WINDOW = 256,
  parameter int SUM_W  = 24,
  localparam int CW    = $clog2(WINDOW + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_a_i,
  input  logic [7:0]       in_b_i,
  input  logic [15:0]      in_prod_i,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [SUM_W-1:0] rpt_sum_err_o,
  output logic [15:0]      rpt_max_err_o,
  output logic [CW-1:0]    rpt_nz_cnt_o,
  output logic             rpt_sat_o
`ifdef X8_ERR_BIAS_EN
  ,
  output logic [SUM_W-1:0] rpt_bias_o
`endif
);

  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             rpt_valid_q, rpt_valid_d;

  // stage 1 (staged error of the last accepted sample)
  logic             s1_vld_q, s1_vld_d;
  logic [15:0]      s1_err_q, s1_err_d;

  // window statistics
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [15:0]      max_q, max_d;
  logic [CW-1:0]    nz_q, nz_d;
  logic             sat_q, sat_d;

  // report copies
  logic [SUM_W-1:0] rpt_sum_q, rpt_sum_d;
  logic [15:0]      rpt_max_q, rpt_max_d;
  logic [CW-1:0]    rpt_nz_q, rpt_nz_d;
  logic             rpt_sat_q, rpt_sat_d;

  logic             accept_s;
  logic             rpt_hs_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             last_s;
  logic [15:0]      exact_s;
  logic [15:0]      err_s;
  logic [SUM_W:0]   sum_wide_s;

`ifdef X8_ERR_BIAS_EN
  logic signed [16:0]      diff_s;
  logic signed [16:0]      s1_diff_q, s1_diff_d;
  logic signed [SUM_W-1:0] bias_q, bias_d;
  logic signed [SUM_W-1:0] rpt_bias_q, rpt_bias_d;
  logic signed [SUM_W:0]   bias_wide_s;
`endif

  // Sample path: exact product, absolute error and handshake qualifiers.
  // in_ready_q is only ever 1 in ACCUM, so it doubles as the state qualifier.
  always_comb begin
    exact_s   = 16'(in_a_i) * 16'(in_b_i);
    if (in_prod_i >= exact_s) begin
      err_s = in_prod_i - exact_s;
    end else begin
      err_s = exact_s - in_prod_i;
    end
    accept_s  = in_valid_i & in_ready_q & ~clear_i;
    rpt_hs_s  = rpt_valid_q & rpt_ready_i;
    cnt_inc_s = cnt_q + CW'(1);
    last_s    = (cnt_inc_s == WIN_C);
`ifdef X8_ERR_BIAS_EN
    diff_s    = $signed({1'b0, in_prod_i}) - $signed({1'b0, exact_s});
`endif
  end

  // FSM next state; ready/valid outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s && last_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          state_d = ST_REPORT;
        end
        ST_REPORT: begin
          if (rpt_hs_s) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_REPORT;
          end
        end
        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
    in_ready_d  = (state_d == ST_ACCUM);
    rpt_valid_d = (state_d == ST_REPORT);
  end

  // Stage 1 capture, stage 2 fold, window counter and report copies.
  always_comb begin
    s1_vld_d   = accept_s;
    s1_err_d   = s1_err_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    max_d      = max_q;
    nz_d       = nz_q;
    sat_d      = sat_q;
    rpt_sum_d  = rpt_sum_q;
    rpt_max_d  = rpt_max_q;
    rpt_nz_d   = rpt_nz_q;
    rpt_sat_d  = rpt_sat_q;
    sum_wide_s = {1'b0, sum_q} + (SUM_W + 1)'(s1_err_q);
`ifdef X8_ERR_BIAS_EN
    s1_diff_d   = s1_diff_q;
    bias_d      = bias_q;
    rpt_bias_d  = rpt_bias_q;
    bias_wide_s = (SUM_W + 1)'(bias_q) + (SUM_W + 1)'(s1_diff_q);
`endif

    if (accept_s) begin
      s1_err_d = err_s;
`ifdef X8_ERR_BIAS_EN
      s1_diff_d = diff_s;
`endif
    end else begin
      s1_err_d = s1_err_q;
    end

    if (clear_i || rpt_hs_s) begin
      // a consumed or flushed report also restarts the window
      s1_vld_d  = 1'b0;
      cnt_d     = '0;
      sum_d     = '0;
      max_d     = 16'd0;
      nz_d      = '0;
      sat_d     = 1'b0;
      rpt_sum_d = '0;
      rpt_max_d = 16'd0;
      rpt_nz_d  = '0;
      rpt_sat_d = 1'b0;
`ifdef X8_ERR_BIAS_EN
      bias_d     = '0;
      rpt_bias_d = '0;
`endif
    end else begin
      if (accept_s) begin
        cnt_d = cnt_inc_s;
      end else begin
        cnt_d = cnt_q;
      end

      if (s1_vld_q) begin
        // carry out of the extended sum means the accumulator overflowed
        if (sum_wide_s[SUM_W]) begin
          sum_d = '1;
          sat_d = 1'b1;
        end else begin
          sum_d = sum_wide_s[SUM_W-1:0];
        end
        if (s1_err_q > max_q) begin
          max_d = s1_err_q;
        end else begin
          max_d = max_q;
        end
        if (s1_err_q != 16'd0) begin
          nz_d = nz_q + CW'(1);
        end else begin
          nz_d = nz_q;
        end
`ifdef X8_ERR_BIAS_EN
        // signed overflow shows as disagreement of the two top bits
        if (bias_wide_s[SUM_W] != bias_wide_s[SUM_W-1]) begin
          sat_d = 1'b1;
          if (bias_wide_s[SUM_W]) begin
            bias_d = {1'b1, {(SUM_W - 1){1'b0}}};
          end else begin
            bias_d = {1'b0, {(SUM_W - 1){1'b1}}};
          end
        end else begin
          bias_d = bias_wide_s[SUM_W-1:0];
        end
`endif
      end else begin
        sum_d = sum_q;
      end

      // snapshot includes the fold of the final sample done in DRAIN
      if (state_q == ST_DRAIN) begin
        rpt_sum_d = sum_d;
        rpt_max_d = max_d;
        rpt_nz_d  = nz_d;
        rpt_sat_d = sat_d;
`ifdef X8_ERR_BIAS_EN
        rpt_bias_d = bias_d;
`endif
      end else begin
        rpt_sum_d = rpt_sum_q;
      end
    end
  end

  // State, pipeline, statistics and report registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_ACCUM;
      in_ready_q  <= 1'b0;
      rpt_valid_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_err_q    <= 16'd0;
      cnt_q       <= '0;
      sum_q       <= '0;
      max_q       <= 16'd0;
      nz_q        <= '0;
      sat_q       <= 1'b0;
      rpt_sum_q   <= '0;
      rpt_max_q   <= 16'd0;
      rpt_nz_q    <= '0;
      rpt_sat_q   <= 1'b0;
`ifdef X8_ERR_BIAS_EN
      s1_diff_q   <= '0;
      bias_q      <= '0;
      rpt_bias_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      rpt_valid_q <= rpt_valid_d;
      s1_vld_q    <= s1_vld_d;
      s1_err_q    <= s1_err_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      nz_q        <= nz_d;
      sat_q       <= sat_d;
      rpt_sum_q   <= rpt_sum_d;
      rpt_max_q   <= rpt_max_d;
      rpt_nz_q    <= rpt_nz_d;
      rpt_sat_q   <= rpt_sat_d;
`ifdef X8_ERR_BIAS_EN
      s1_diff_q   <= s1_diff_d;
      bias_q      <= bias_d;
      rpt_bias_q  <= rpt_bias_d;
`endif
    end
  end

  assign in_ready_o    = in_ready_q;
  assign rpt_valid_o   = rpt_valid_q;
  assign rpt_sum_err_o = rpt_sum_q;
  assign rpt_max_err_o = rpt_max_q;
  assign rpt_nz_cnt_o  = rpt_nz_q;
  assign rpt_sat_o     = rpt_sat_q;
`ifdef X8_ERR_BIAS_EN
  assign rpt_bias_o    = rpt_bias_q;
`endif

endmodule
